muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 32, the number of divide iteration cycles, one quotient bit per cycle.
REQ-002 SHALL have ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flushE  in  1  cancels any accepted or in-flight operation.
- op_valid  in  1  execute-stage instruction present.
- op  in  3  operation code.
- a  in  32  rs operand / dividend.
- b  in  32  rt operand / divisor.
- stall  out  1  holds the pipeline.
- done  out  1  one-cycle result pulse.
- we_o  out  2  HI/LO write enables: bit1 = HI, bit0 = LO.
- hi_o  out  32  HI write data.
- lo_o  out  32  LO write data.

Function
REQ-003 SHALL decode op as: 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; code 111 SHALL be treated as NONE.
REQ-004 SHALL use an FSM with states IDLE, MUL, DIV, DONE.
REQ-005 SHALL accept an operation only in IDLE with op_valid=1, op≠NONE and flushE=0; a and b SHALL be captured at acceptance.
REQ-006 SHALL ignore op, a and b outside IDLE.
REQ-007 Transitions:
- IDLE→MUL on accepted MULT/MULTU.
- IDLE→DIV on accepted DIV/DIVU with b≠0.
- IDLE→DONE on accepted MTHI/MTLO, or DIV/DIVU with b=0.
- MUL→DONE after 1 cycle.
- DIV→DONE after DIV_CYCLES cycles.
- DONE→IDLE always.
REQ-008 Latency from acceptance edge to done=1:
- MTHI/MTLO and divide-by-zero: 1 cycle.
- MULT/MULTU: 2 cycles.
- DIV/DIVU: DIV_CYCLES+1 cycles.
REQ-009 SHALL drive done=1 only in DONE, for exactly one cycle.
REQ-010 Outputs in DONE:
- MULT/MULTU/DIV/DIVU: we_o=11.
- MTHI: we_o=10, hi_o=a.
- MTLO: we_o=01, lo_o=a.
REQ-011 SHALL drive we_o=00 in every state other than DONE.
REQ-012 SHALL hold hi_o/lo_o registered and stable throughout DONE.
REQ-013 SHALL compute stall = op_valid & (op≠NONE) & ~done & ~flushE, combinationally.
REQ-014 MULT SHALL form a signed 64-bit product and MULTU an unsigned one; hi_o = product[63:32], lo_o = product[31:0].
REQ-015 DIV/DIVU SHALL use restoring shift-subtract on magnitudes (DIV) or raw values (DIVU); lo_o = quotient, hi_o = remainder.
REQ-016 Sign fix-up for DIV SHALL be applied in the transition into DONE:
- quotient negated when a[31]^b[31].
- remainder negated when a[31].
REQ-017 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo_o=0x80000000, hi_o=0 (wrap, no exception).
REQ-018 Divide by zero SHALL yield lo_o=0xFFFFFFFF, hi_o=a, for both signed and unsigned.
REQ-019 flushE=1 in MUL, DIV or DONE SHALL force IDLE on the next edge, with we_o=00 and done=0 in the flush cycle; no HI/LO write SHALL occur.
REQ-020 flushE=1 in IDLE SHALL block acceptance that cycle.

Reset
REQ-021 rst=1 SHALL, on the next rising edge and with priority over flushE, drive:
- state = IDLE
- hi_o = lo_o = 0
- we_o = 00
- done = 0
- divider iteration counter and partial remainder cleared.
REQ-022 rst asserted mid-operation SHALL abandon the operation with no write; the first acceptance SHALL be possible in the cycle after rst deasserts.

Structure
REQ-023 Op encodings, the FSM state type and DIV_CYCLES default SHALL reside in shared package muldiv_pkg.
REQ-024 The iterative divider SHALL be sub-module div_radix2:
- inputs: start, signed_op, dividend, divisor.
- outputs: quotient, remainder, valid.
- handles magnitude conversion and sign fix-up internally.
REQ-025 The multiplier SHALL be a single registered 33x33 signed product (operands sign- or zero-extended), stored in MUL.

Verification
REQ-026 MULT a=0xFFFFFFFE, b=3 → done at cycle 2; hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA, we_o=11.
REQ-027 DIVU a=100, b=7 → stall high for 32 cycles, done at cycle 33; lo_o=14, hi_o=2.
REQ-028 DIV a=-7 (0xFFFFFFF9), b=2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 0x80000000 / -1 → lo_o=0x80000000, hi_o=0.
REQ-029 DIV a=5, b=0 → done at cycle 1; lo_o=0xFFFFFFFF, hi_o=5. MTLO a=0x1234 → we_o=01, lo_o=0x1234.
REQ-030 Cancellation: flushE pulse at cycle 10 of DIVU → IDLE next edge, we_o never nonzero; rst at cycle 5 of DIV → all outputs 0, the next MULTU accepted normally.
REQ-031 Back-to-back: DIVU held with op_valid=1 → exactly one done pulse, no re-acceptance in DONE; a new op presented the cycle after DONE is accepted.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM state type and defaults for muldiv_unit
package muldiv_pkg;

  localparam int DIV_CYCLES_DEF = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  // The reserved code behaves exactly like NONE.
  function automatic logic is_none(input op_e op);
    return (op == OP_NONE) || (op == OP_RSVD);
  endfunction

  // HI/LO write enables presented in DONE: bit1 = HI, bit0 = LO.
  function automatic logic [1:0] wr_mask(input op_e op);
    case (op)
      OP_MTHI:          return 2'b10;
      OP_MTLO:          return 2'b01;
      OP_NONE, OP_RSVD: return 2'b00;
      default:          return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_div_radix2.sv
// rtl/muldiv_div_radix2.sv - iterative restoring radix-2 divider, one quotient bit per cycle
// Ports: clk, rst (sync, active-high); start loads dividend/divisor and
// signed_op; quotient/remainder are the sign-corrected result of the final
// step and are meaningful while valid = 1 (the last iteration cycle).
module div_radix2
  import muldiv_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        valid
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   rem, quo, dvs;
  logic          neg_q, neg_r;
  logic [32:0]   rem_sh;
  logic          ge;
  logic [31:0]   rem_n, quo_n;

  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s && x[31]) ? -x : x;
  endfunction

  // quo doubles as the dividend shift register: its MSB feeds the
  // partial remainder while quotient bits enter at the LSB.
  always_comb begin
    rem_sh = {rem, quo[31]};
    ge     = (rem_sh >= {1'b0, dvs});
    rem_n  = ge ? 32'(rem_sh - {1'b0, dvs}) : rem_sh[31:0];
    quo_n  = {quo[30:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      cnt   <= CW'(DIV_CYCLES);
      rem   <= '0;
      quo   <= mag(dividend, signed_op);
      dvs   <= mag(divisor, signed_op);
      neg_q <= signed_op & (dividend[31] ^ divisor[31]);
      neg_r <= signed_op & dividend[31];
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      rem <= rem_n;
      quo <= quo_n;
    end
  end

  // The last step is combinational so its corrected result can be
  // captured by the parent on the same edge that leaves DIV.
  assign valid     = (cnt == CW'(1));
  assign quotient  = neg_q ? -quo_n : quo_n;
  assign remainder = neg_r ? -rem_n : rem_n;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - HI/LO multiply/divide unit with pipeline stall handshake
// Ports: clk, rst (sync, active-high), flushE cancels work; op_valid/op/a/b
// present an execute-stage instruction; stall holds the pipeline; done pulses
// one cycle with we_o (bit1 HI, bit0 LO) and registered hi_o/lo_o data.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushE,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic        done,
  output logic [1:0]  we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  state_e      state, state_n;
  op_e         op_in, op_r;
  logic        accept, is_mul, is_div, b_zero;
  logic [32:0] mul_a, mul_b;
  logic [63:0] prod;
  logic [31:0] div_quo, div_rem;
  logic        div_valid;

  assign op_in  = op_e'(op);
  assign is_mul = (op_in == OP_MULT) || (op_in == OP_MULTU);
  assign is_div = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign b_zero = (b == 32'd0);
  assign accept = (state == S_IDLE) && op_valid && !flushE && !is_none(op_in);

  // 33x33 signed product of the extended operands; the low 64 bits are
  // the exact result for both signed and unsigned 32-bit inputs.
  assign prod = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};

  assign stall = op_valid && !is_none(op_in) && !done && !flushE;

  div_radix2 #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_div && !b_zero),
    .signed_op (op_in == OP_DIV),
    .dividend  (a),
    .divisor   (b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    we_o    = 2'b00;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_mul)                state_n = S_MUL;
          else if (is_div && !b_zero) state_n = S_DIV;
          else                       state_n = S_DONE;
        end
      end
      S_MUL:  state_n = S_DONE;
      S_DIV:  if (div_valid) state_n = S_DONE;
      S_DONE: begin
        state_n = S_IDLE;
        done    = 1'b1;
        we_o    = wr_mask(op_r);
      end
      default: state_n = S_IDLE;
    endcase
    // A flush suppresses the write in the very cycle it is seen.
    if (flushE) begin
      state_n = S_IDLE;
      done    = 1'b0;
      we_o    = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r  <= OP_NONE;
      mul_a <= '0;
      mul_b <= '0;
      hi_o  <= '0;
      lo_o  <= '0;
    end else if (!flushE) begin
      if (accept) begin
        op_r  <= op_in;
        mul_a <= {(op_in == OP_MULT) & a[31], a};
        mul_b <= {(op_in == OP_MULT) & b[31], b};
        if (op_in == OP_MTHI) hi_o <= a;
        if (op_in == OP_MTLO) lo_o <= a;
        if (is_div && b_zero) begin
          hi_o <= a;
          lo_o <= '1;
        end
      end
      if (state == S_MUL) begin
        hi_o <= prod[63:32];
        lo_o <= prod[31:0];
      end
      if (state == S_DIV && div_valid) begin
        hi_o <= div_rem;
        lo_o <= div_quo;
      end
    end
  end

endmodule
